// File: rtl/normalise_pack_if.sv
// Handshake bundle between the HCORDIC datapath and the normalise/round/pack back end.
// A transfer happens on a rising clock edge where valid && ready; the source holds its data until then.
interface normalise_pack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   idle_Pack;
  logic [31:0]            sin_Pack;
  logic [EXP_W+MAN_W:0]   zin_Pack;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            sout_Pack;
  logic                   overflow_Pack;

  modport master (
    output in_valid, idle_Pack, sin_Pack, zin_Pack, out_ready,
    input  in_ready, out_valid, sout_Pack, overflow_Pack
  );

  modport slave (
    input  in_valid, idle_Pack, sin_Pack, zin_Pack, out_ready,
    output in_ready, out_valid, sout_Pack, overflow_Pack
  );
endinterface

// File: rtl/normalise_pack.sv
// Normalises an unpacked HCORDIC result one bit per cycle, rounds to nearest-even
// and packs it into an IEEE-754 single; pre-packed special cases bypass the datapath.
module normalise_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
) (
  input  logic               clock,
  input  logic               reset,
  normalise_pack_if.slave    bus,
  output logic [2:0]         fsm_state
);
  localparam int EW = EXP_W + 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] NORM  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] PACK  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [EW-1:0]    E_ONE = EW'(1);
  localparam logic [EW-1:0]    E_SAT = EW'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0] M_RND = MAN_W'(8);

  logic [2:0]       state;
  logic             s;
  logic [EW-1:0]    e;
  logic [MAN_W-1:0] m;
  logic [31:0]      sout;
  logic             ovf;

  logic [MAN_W-1:0] m_adj;
  logic [EW-1:0]    e_adj;
  logic             rnd_up;

  // Rounding carry out of the mantissa is absorbed here before packing.
  always_comb begin
    m_adj = m;
    e_adj = e;
    if (m[MAN_W-1]) begin
      m_adj = m >> 1;
      e_adj = e + E_ONE;
    end
  end

  assign rnd_up = m[2] & (m[1] | m[0] | m[3]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      sout  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.idle_Pack) begin
              sout  <= bus.sin_Pack;
              state <= DONE;
            end else if (bus.zin_Pack[MAN_W-1:0] == '0) begin
              sout  <= {bus.zin_Pack[EXP_W+MAN_W], 31'b0};
              state <= DONE;
            end else begin
              s     <= bus.zin_Pack[EXP_W+MAN_W];
              e     <= {2'b00, bus.zin_Pack[EXP_W+MAN_W-1:MAN_W]};
              m     <= bus.zin_Pack[MAN_W-1:0];
              state <= NORM;
            end
          end
        end
        NORM: begin
          // Left shifting stops at e==1, leaving a denormal with m[26]==0.
          if (m[MAN_W-1]) begin
            m <= {1'b0, m[MAN_W-1:2], m[1] | m[0]};
            e <= e + E_ONE;
          end else if (!m[MAN_W-2] && (e > E_ONE)) begin
            m <= m << 1;
            e <= e - E_ONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_up) m <= m + M_RND;
          state <= PACK;
        end
        PACK: begin
          if (e_adj >= E_SAT) begin
            sout <= {s, {EXP_W{1'b1}}, {(31-EXP_W){1'b0}}};
            ovf  <= 1'b1;
          end else begin
            sout <= {s, m_adj[MAN_W-2] ? e_adj[EXP_W-1:0] : {EXP_W{1'b0}}, m_adj[MAN_W-3:3]};
          end
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.sout_Pack     = sout;
  assign bus.overflow_Pack = ovf;
  assign fsm_state         = state;
endmodule
